// File: rtl/test_sequencer_if.sv
// Check-word handshake between a scoreboard feed and the test sequencer.
//   master : scoreboard side, drives chk_valid/chk_actual/chk_expected
//   slave  : sequencer side, drives chk_ready
interface test_sequencer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  chk_valid;
  logic                  chk_ready;
  logic [DATA_WIDTH-1:0] chk_actual;
  logic [DATA_WIDTH-1:0] chk_expected;

  modport master (
    output chk_valid,
    output chk_actual,
    output chk_expected,
    input  chk_ready
  );

  modport slave (
    input  chk_valid,
    input  chk_actual,
    input  chk_expected,
    output chk_ready
  );
endinterface

// File: rtl/test_sequencer.sv
// test_sequencer: owns one test run for the status monitor. Pulses the
// begin indication, accepts num_checks actual/expected pairs over a
// valid/ready handshake, runs a stall watchdog, and holds the verdict
// (pass, fail, or pass+fail = "finished" on timeout) until the next start.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         one-cycle request to begin a test (ignored in BEGIN/RUN)
//   i_num_checks    checks in this test, latched when start is accepted
//   chk_if          check-word handshake (slave side)
//   o_status_reset  one-cycle begin pulse to the status monitor
//   o_status_pass   pass level
//   o_status_fail   fail level
//   o_busy          high in BEGIN and RUN
//   o_check_count   accepted checks this test
//   o_err_count     mismatches this test, saturating
//
// Optional build macro: TEST_SEQ_EARLY_FAIL_EN -- the first mismatching
// accept ends the test with the fail verdict.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// BEGIN | one cycle: status_reset pulse, counters and watchdog cleared
// RUN   | accepting checks, watchdog counting idle cycles
// DONE  | verdict held until start or reset
module test_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT     = 100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [COUNT_WIDTH-1:0] i_num_checks,
  test_sequencer_if.slave        chk_if,
  output logic                   o_status_reset,
  output logic                   o_status_pass,
  output logic                   o_status_fail,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_check_count,
  output logic [COUNT_WIDTH-1:0] o_err_count
);

  // Watchdog only needs to reach TIMEOUT-1; expiry is detected on that value.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEGIN = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_num;
  logic [COUNT_WIDTH-1:0] r_check_count;
  logic [COUNT_WIDTH-1:0] r_err_count;
  logic [WD_W-1:0]        r_wd;
  logic                   r_ready;
  logic                   r_status_reset;
  logic                   r_pass;
  logic                   r_fail;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_mismatch;
  logic                   w_early_stop;
  logic [COUNT_WIDTH-1:0] w_cnt_next;
  logic [COUNT_WIDTH-1:0] w_err_next;

  assign w_accept   = chk_if.chk_valid & r_ready;
  assign w_mismatch = DATA_WIDTH'(chk_if.chk_actual) != DATA_WIDTH'(chk_if.chk_expected);
  assign w_cnt_next = r_check_count + 1'b1;
  // Saturate so a long failing run never wraps back to a clean-looking zero.
  assign w_err_next = (w_mismatch && (r_err_count != '1)) ? r_err_count + 1'b1
                                                          : r_err_count;

`ifdef TEST_SEQ_EARLY_FAIL_EN
  assign w_early_stop = w_mismatch;
`else
  assign w_early_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_num          <= '0;
      r_check_count  <= '0;
      r_err_count    <= '0;
      r_wd           <= '0;
      r_ready        <= 1'b0;
      r_status_reset <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_status_reset <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state        <= BEGIN;
            r_num          <= i_num_checks;
            r_check_count  <= '0;
            r_err_count    <= '0;
            r_wd           <= '0;
            r_status_reset <= 1'b1;
            r_pass         <= 1'b0;
            r_fail         <= 1'b0;
            r_busy         <= 1'b1;
          end
        end
        BEGIN: begin
          // An empty test passes without ever raising chk_ready.
          if (r_num == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_wd          <= '0;
            r_check_count <= w_cnt_next;
            r_err_count   <= w_err_next;
            if ((w_cnt_next == r_num) || w_early_stop) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_pass  <= (w_err_next == '0);
              r_fail  <= (w_err_next != '0);
            end
          end else if (TIMEOUT != 0) begin
            if (r_wd == WD_LAST) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
              r_fail  <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chk_if.chk_ready = r_ready;
  assign o_status_reset   = r_status_reset;
  assign o_status_pass    = r_pass;
  assign o_status_fail    = r_fail;
  assign o_busy           = r_busy;
  assign o_check_count    = r_check_count;
  assign o_err_count      = r_err_count;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer (TIMEOUT=8). Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at the same point, so
// each tick() shows the state registered at that edge.
module tb_test_sequencer;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_checks;
  logic          status_reset, status_pass, status_fail, busy;
  logic [CW-1:0] check_count, err_count;

  int n_chk;
  int n_err;

  test_sequencer_if #(.DATA_WIDTH(DW)) chk_bus ();

  test_sequencer #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .TIMEOUT    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_num_checks  (num_checks),
    .chk_if        (chk_bus.slave),
    .o_status_reset(status_reset),
    .o_status_pass (status_pass),
    .o_status_fail (status_fail),
    .o_busy        (busy),
    .o_check_count (check_count),
    .o_err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; BEGIN is visible on return.
  task automatic do_start(input logic [CW-1:0] n);
    start      = 1'b1;
    num_checks = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] e);
    chk_bus.chk_valid    = v;
    chk_bus.chk_actual   = a;
    chk_bus.chk_expected = e;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    num_checks = '0;
    drive(1'b0, '0, '0);
    tick();
    tick();

    // reset values
    chk("rst_ready", chk_bus.chk_ready, 0);
    chk("rst_status_reset", status_reset, 0);
    chk("rst_pass", status_pass, 0);
    chk("rst_fail", status_fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_check_count", check_count, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    tick();

    // 1: four matching pairs, valid held high
    do_start(16'd4);
    chk("t1_begin_pulse", status_reset, 1);
    chk("t1_begin_busy", busy, 1);
    chk("t1_begin_ready", chk_bus.chk_ready, 0);
    drive(1'b1, 16'h1234, 16'h1234);
    tick();
    chk("t1_run_ready", chk_bus.chk_ready, 1);
    chk("t1_run_pulse_gone", status_reset, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(16'h0100 + i), DW'(16'h0100 + i));
      tick();
      chk("t1_count", check_count, i + 1);
    end
    drive(1'b0, '0, '0);
    chk("t1_pass", status_pass, 1);
    chk("t1_fail", status_fail, 0);
    chk("t1_err", err_count, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ready_low", chk_bus.chk_ready, 0);

    // 2: five pairs, pairs 2 and 4 mismatch
    do_start(16'd5);
    chk("t2_begin_cleared", check_count, 0);
    drive(1'b1, 16'h00AA, 16'h00AA);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'h00AA, (i == 2 || i == 4) ? 16'h00AB : 16'h00AA);
      tick();
`ifdef TEST_SEQ_EARLY_FAIL_EN
      if (i == 2) break;
`endif
    end
    drive(1'b0, '0, '0);
    chk("t2_pass", status_pass, 0);
    chk("t2_fail", status_fail, 1);
    chk("t2_busy", busy, 0);
`ifdef TEST_SEQ_EARLY_FAIL_EN
    chk("t2_err", err_count, 1);
    chk("t2_count", check_count, 2);
`else
    chk("t2_err", err_count, 2);
    chk("t2_count", check_count, 5);
`endif

    // 3: timeout after one accept
    do_start(16'd3);
    drive(1'b1, 16'h0005, 16'h0005);
    tick();
    tick();
    drive(1'b0, '0, '0);
    chk("t3_accept_count", check_count, 1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 7) chk("t3_still_busy", busy, 1);
    end
    chk("t3_done_busy", busy, 0);
    chk("t3_pass", status_pass, 1);
    chk("t3_fail", status_fail, 1);
    chk("t3_count", check_count, 1);
    chk("t3_ready_low", chk_bus.chk_ready, 0);

    // 4: num_checks = 0
    do_start(16'd0);
    chk("t4_begin_pulse", status_reset, 1);
    chk("t4_begin_ready", chk_bus.chk_ready, 0);
    chk("t4_begin_pass_clr", status_pass, 0);
    tick();
    chk("t4_done_busy", busy, 0);
    chk("t4_pass", status_pass, 1);
    chk("t4_fail", status_fail, 0);
    chk("t4_ready", chk_bus.chk_ready, 0);
    chk("t4_count", check_count, 0);

    // 5: reset mid-run after 2 of 6 accepts, then a clean rerun
    do_start(16'd6);
    drive(1'b1, 16'h0042, 16'h0042);
    tick();
    tick();
    tick();
    chk("t5_pre_count", check_count, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", chk_bus.chk_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pass", status_pass, 0);
    chk("t5_rst_fail", status_fail, 0);
    chk("t5_rst_count", check_count, 0);
    chk("t5_rst_pulse", status_reset, 0);
    drive(1'b0, '0, '0);
    rst_n = 1'b1;
    tick();
    do_start(16'd6);
    chk("t5_again_pulse", status_reset, 1);
    drive(1'b1, 16'h0077, 16'h0077);
    tick();
    chk("t5_again_ready", chk_bus.chk_ready, 1);
    for (int i = 0; i < 6; i++) tick();
    drive(1'b0, '0, '0);
    chk("t5_again_count", check_count, 6);
    chk("t5_again_pass", status_pass, 1);
    chk("t5_again_fail", status_fail, 0);
    chk("t5_again_busy", busy, 0);

    // 6: start during RUN ignored; start in DONE (fail) restarts
    do_start(16'd2);
    tick();
    do_start(16'd9);
    chk("t6_run_ignored_busy", busy, 1);
    chk("t6_run_ignored_pulse", status_reset, 0);
    chk("t6_run_ignored_ready", chk_bus.chk_ready, 1);
    drive(1'b1, 16'h0001, 16'h0002);
    tick();
    tick();
    drive(1'b0, '0, '0);
    chk("t6_fail_verdict", status_fail, 1);
    chk("t6_fail_busy", busy, 0);
    do_start(16'd3);
    chk("t6_restart_fail_clr", status_fail, 0);
    chk("t6_restart_pass_clr", status_pass, 0);
    chk("t6_restart_pulse", status_reset, 1);
    chk("t6_restart_count", check_count, 0);
    chk("t6_restart_err", err_count, 0);
    tick();
    chk("t6_restart_run", chk_bus.chk_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/test_sequencer.md
# test_sequencer

Bench-side sequencer and checker that drives the status/pass/fail interface of the test status monitor. It owns one test run: it pulses the monitor's begin indication, accepts a fixed number of actual/expected comparisons over a valid/ready handshake, runs a stall watchdog, and then holds a pass, fail or finished verdict. It sits between a DUT output scoreboard feed and the status monitor in each dnnweaver unit-test bench.

## Interface
- DATA_WIDTH, 16, width of compared words
- COUNT_WIDTH, 16, width of check/error counters and num_checks
- TIMEOUT, 100, max consecutive RUN cycles without an accepted check; 0 disables watchdog

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a test
- num_checks  in  COUNT_WIDTH  checks in this test, sampled when start is accepted
- chk_valid  in  1  check word pair present
- chk_ready  out  1  sequencer accepts a check
- chk_actual  in  DATA_WIDTH  DUT value
- chk_expected  in  DATA_WIDTH  golden value
- status_reset  out  1  begin indication to the status monitor
- status_pass  out  1  pass level to the status monitor
- status_fail  out  1  fail level to the status monitor
- busy  out  1  high in BEGIN and RUN
- check_count  out  COUNT_WIDTH  accepted checks this test
- err_count  out  COUNT_WIDTH  mismatches this test, saturating

## Operation
- States: IDLE, BEGIN, RUN, DONE. All outputs are registered.
- IDLE -> BEGIN on start. DONE -> BEGIN on start, which restarts the test. In BEGIN and RUN, start is ignored.
- BEGIN lasts one cycle:
  - status_reset=1, status_pass=0, status_fail=0.
  - num_checks is latched.
  - check_count, err_count and the watchdog are cleared.
  - Next state is RUN.
- RUN:
  - chk_ready=1; status_reset=0.
  - An accept is chk_valid&chk_ready. Each accept increments check_count.
  - err_count increments when chk_actual!=chk_expected. It saturates at all-ones.
- RUN -> DONE when check_count equals the latched num_checks. This includes num_checks=0, which produces a pass with no accepts.
- Watchdog:
  - Clears on every accept and in BEGIN.
  - Otherwise increments each RUN cycle.
  - When it reaches TIMEOUT, RUN -> DONE with the timeout verdict.
- DONE verdict is held until the next start or reset:
  - err_count==0 and no timeout: status_pass=1, status_fail=0.
  - err_count>0 and no timeout: status_pass=0, status_fail=1.
  - Timeout: status_pass=1, status_fail=1 ("finished").
- Simultaneous events:
  - An accept in the cycle the watchdog would expire wins: the watchdog clears.
  - A final accept completes the test normally.
- Reset asserted mid-test, at any time:
  - State goes to IDLE immediately.
  - All outputs go to 0, including status_pass and status_fail.

## Timing
- Reset values: chk_ready=0, status_reset=0, status_pass=0, status_fail=0, busy=0, check_count=0, err_count=0.
- start sampled high at edge t:
  - BEGIN is visible after edge t, with status_reset=1 and busy=1 for exactly one cycle.
  - RUN is visible after edge t+1, with chk_ready=1.
- Accept of the final check at edge k: DONE is visible after edge k, with the verdict, busy=0 and chk_ready=0. The error count from that final check is included.
- num_checks=0: DONE is visible one cycle after BEGIN.
- Timeout: after TIMEOUT consecutive non-accept RUN cycles, DONE is visible on the following cycle.
- check_count and err_count update one cycle after each accept. They are held in DONE.

## Configuration
- TEST_SEQ_EARLY_FAIL_EN defined:
  - The first mismatching accept moves RUN -> DONE with the fail verdict.
  - check_count stops at that check's index, and err_count=1.
- TEST_SEQ_EARLY_FAIL_EN undefined: all num_checks checks are always consumed before DONE.

## Test plan
- Reset then start with num_checks=4, four matching pairs, chk_valid held high -> status_reset pulses 1 cycle, accepts on 4 consecutive cycles, then status_pass=1, status_fail=0, err_count=0.
- num_checks=5, pairs 2 and 4 mismatch (0x00AA vs 0x00AB) -> status_pass=0, status_fail=1, err_count=2, check_count=5. With TEST_SEQ_EARLY_FAIL_EN: DONE after pair 2, check_count=2, err_count=1.
- TIMEOUT=8, num_checks=3, one accept then chk_valid low -> DONE exactly 8 RUN cycles after the last accept, status_pass=1, status_fail=1, check_count=1.
- start with num_checks=0 -> BEGIN, then DONE pass on the next cycle, no chk_ready cycles.
- Assert reset during RUN after 2 of 6 accepts -> all outputs 0 at once. A later start runs cleanly: pulse, then 6 accepts, then pass.
- start pulsed during RUN, and again in DONE (fail verdict) -> first is ignored. Second clears status_fail in BEGIN, re-pulses status_reset and zeros the counters.
